// File: rtl/output_port_controller.sv
// Output port scheduler: round-robin grant across input ports, one downstream
// packet credit per grant, then drives select and flit valid for one packet.
module output_port_controller #(
    parameter int PORTS        = 4,
    parameter int PACKET_FLITS = 5,
    parameter int CREDITS      = 4,
    parameter int SEL_W        = (PORTS > 1) ? $clog2(PORTS) : 1,
    parameter int CRD_W        = $clog2(CREDITS + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [PORTS-1:0] request_din,
    input  logic             credit_in_din,
    output logic [PORTS-1:0] transfer_strobe_dout,
    output logic [SEL_W-1:0] port_select_dout,
    output logic             flit_valid_dout,
    output logic             port_busy_dout,
    output logic [CRD_W-1:0] credits_dout
);

    localparam int CNT_W = $clog2(PACKET_FLITS + 1);

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        ACTIVE
    } state_t;

    state_t           state_q, state_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CRD_W-1:0] crd_q, crd_d;
    logic [SEL_W-1:0] win;
    logic             found;
    logic             eligible;
    logic             granting;

    // Two passes: indices at or above the pointer first, then the wrap-around.
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int i = 0; i < PORTS; i++) begin
            if (!found && request_din[i] && i >= int'(ptr_q)) begin
                found = 1'b1;
                win   = SEL_W'(i);
            end
        end
        for (int i = 0; i < PORTS; i++) begin
            if (!found && request_din[i]) begin
                found = 1'b1;
                win   = SEL_W'(i);
            end
        end
    end

    assign eligible = found && (crd_q != '0);
    assign granting = (state_q == GRANT);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (eligible) begin
                    sel_d   = win;
                    ptr_d   = (win == SEL_W'(PORTS - 1)) ? '0 : win + 1'b1;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                cnt_d   = CNT_W'(PACKET_FLITS);
                state_d = ACTIVE;
            end
            ACTIVE: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A return and a spend in the same cycle cancel out.
    always_comb begin
        crd_d = crd_q;
        if (credit_in_din && !granting) begin
            if (crd_q != CRD_W'(CREDITS)) begin
                crd_d = crd_q + 1'b1;
            end
        end else if (granting && !credit_in_din) begin
            crd_d = crd_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            sel_q   <= '0;
            cnt_q   <= '0;
            crd_q   <= CRD_W'(CREDITS);
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            crd_q   <= crd_d;
        end
    end

    always_comb begin
        transfer_strobe_dout = '0;
        for (int i = 0; i < PORTS; i++) begin
            transfer_strobe_dout[i] = granting && (sel_q == SEL_W'(i));
        end
    end

    assign port_select_dout = sel_q;
    assign flit_valid_dout  = (state_q == ACTIVE);
    assign port_busy_dout   = (state_q != IDLE);
    assign credits_dout     = crd_q;

endmodule

// File: tb/tb_output_port_controller.sv
// Randomized bench for output_port_controller with a cycle-count reference
// model feeding expectation queues that a separate monitor drains.
module tb_output_port_controller;

    localparam int P  = 4;
    localparam int PF = 5;
    localparam int C  = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [P-1:0] req;
    logic         cin;
    logic [P-1:0] strobe;
    logic [1:0]   sel;
    logic         fv;
    logic         busy;
    logic [2:0]   credits;

    logic [2:0]   req3;
    logic         cin3;
    logic [2:0]   strobe3;
    logic [1:0]   sel3;
    logic         fv3;
    logic         busy3;
    logic [2:0]   credits3;

    always #5 clk = ~clk;

    output_port_controller #(.PORTS(P), .PACKET_FLITS(PF), .CREDITS(C)) dut (
        .clk(clk),
        .reset(rst_n),
        .request_din(req),
        .credit_in_din(cin),
        .transfer_strobe_dout(strobe),
        .port_select_dout(sel),
        .flit_valid_dout(fv),
        .port_busy_dout(busy),
        .credits_dout(credits)
    );

    output_port_controller #(.PORTS(3), .PACKET_FLITS(PF), .CREDITS(C)) dut3 (
        .clk(clk),
        .reset(rst_n),
        .request_din(req3),
        .credit_in_din(cin3),
        .transfer_strobe_dout(strobe3),
        .port_select_dout(sel3),
        .flit_valid_dout(fv3),
        .port_busy_dout(busy3),
        .credits_dout(credits3)
    );

    typedef struct {
        int port;
        int cyc;
    } gexp_t;

    typedef struct {
        int cred;
        bit fv;
        bit busy;
        int sel;
    } cexp_t;

    gexp_t gq[$];
    cexp_t cq[$];
    int    q3[$];

    int cyc = 0;
    int errors = 0;
    int checks = 0;
    bit finish_req = 1'b0;
    logic [P-1:0] last_strobe = '0;
    logic [2:0]   last3 = '0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: grant timing expressed as cycle arithmetic.
    int    m_cred, m_ptr, m_sel, m_gcyc, m_free, m_w, m_gnow, m_n;
    cexp_t m_e;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_cred = C;
            m_ptr  = 0;
            m_sel  = 0;
            m_gcyc = -100;
            m_free = 0;
            gq.delete();
            cq.delete();
            m_e.cred = C;
            m_e.fv   = 1'b0;
            m_e.busy = 1'b0;
            m_e.sel  = 0;
            cq.push_back(m_e);
        end else begin
            m_gnow = (cyc == m_gcyc) ? 1 : 0;
            if (cyc >= m_free && req != '0 && m_cred > 0) begin
                m_w = -1;
                for (int k = 0; k < P; k++) begin
                    if (m_w < 0 && req[(m_ptr + k) % P]) m_w = (m_ptr + k) % P;
                end
                gq.push_back('{m_w, cyc + 1});
                m_gcyc = cyc + 1;
                m_free = cyc + 2 + PF;
                m_ptr  = (m_w + 1) % P;
                m_sel  = m_w;
            end
            m_cred = m_cred + int'(cin) - m_gnow;
            if (m_cred > C) m_cred = C;
            m_n = cyc + 1;
            m_e.cred = m_cred;
            m_e.fv   = (m_n > m_gcyc && m_n <= m_gcyc + PF);
            m_e.busy = (m_n >= m_gcyc && m_n <= m_gcyc + PF);
            m_e.sel  = m_sel;
            cq.push_back(m_e);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    cexp_t e;
    gexp_t g;
    int    x;

    always @(negedge clk) begin
        if (finish_req) begin
            chk("grants_pending", gq.size(), 0);
            chk("dut3_pending", q3.size(), 0);
            $display("Result: errors=%0d of %0d checks", errors, checks);
            $finish;
        end else if (!rst_n) begin
            chk("rst_strobe", int'(strobe), 0);
            chk("rst_sel", int'(sel), 0);
            chk("rst_flit_valid", int'(fv), 0);
            chk("rst_busy", int'(busy), 0);
            chk("rst_credits", int'(credits), C);
        end else begin
            if (cq.size() == 0) begin
                chk("model_queue_empty", 1, 0);
            end else begin
                e = cq.pop_front();
                chk("credits", int'(credits), e.cred);
                chk("flit_valid", int'(fv), int'(e.fv));
                chk("busy", int'(busy), int'(e.busy));
                chk("port_select", int'(sel), e.sel);
            end
            if (strobe != '0) begin
                if (gq.size() == 0) begin
                    chk("unexpected_strobe", int'(strobe), 0);
                end else begin
                    g = gq.pop_front();
                    chk("strobe", int'(strobe), 1 << g.port);
                    chk("strobe_cycle", cyc, g.cyc);
                end
            end else if (gq.size() > 0 && gq[0].cyc <= cyc) begin
                g = gq.pop_front();
                chk("missed_strobe", 0, 1 << g.port);
            end
            if (strobe3 != '0) begin
                if (q3.size() == 0) begin
                    chk("dut3_unexpected", int'(strobe3), 0);
                end else begin
                    x = q3.pop_front();
                    chk("dut3_strobe", int'(strobe3), 1 << x);
                    chk("dut3_sel", int'(sel3), x);
                end
            end
        end
        last_strobe = strobe;
        last3       = strobe3;
    end

    task automatic step(input logic [P-1:0] r, input logic c);
        @(posedge clk);
        #1;
        req = r;
        cin = c;
    endtask

    initial begin
        rst_n = 1'b0;
        req   = '0;
        cin   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        req   = 4'b0100;
        repeat (12) step(req & ~last_strobe, 1'b0);

        repeat (40) step(4'hF, 1'b1);

        repeat (40) step(4'hF, 1'b0);
        step(4'hF, 1'b1);
        repeat (12) step(4'hF, 1'b0);

        step(4'h0, 1'b1);
        step(4'h0, 1'b1);
        step(4'h0, 1'b0);
        step(4'b0001, 1'b0);
        step(4'h0, 1'b1);
        repeat (10) step(4'h0, 1'b0);
        repeat (6) step(4'h0, 1'b1);

        repeat (800) begin : rnd
            logic [P-1:0] r;
            r = req & ~last_strobe;
            for (int i = 0; i < P; i++) begin
                if (!r[i] && $urandom_range(3) == 0) r[i] = 1'b1;
            end
            step(r, $urandom_range(3) == 0);
        end

        repeat (10) step(4'h0, 1'b1);
        for (int k = 0; k < 20 && last_strobe == '0; k++) step(4'hF, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        req   = 4'b1010;
        rst_n = 1'b1;
        repeat (12) step(req & ~last_strobe, 1'b0);

        repeat (12) step(4'h0, 1'b0);
        finish_req = 1'b1;
    end

    initial begin
        req3 = '0;
        cin3 = 1'b0;
        @(posedge rst_n);
        @(posedge clk);
        #1;
        q3.push_back(2);
        req3 = 3'b100;
        for (int k = 0; k < 20 && last3 == '0; k++) begin
            @(posedge clk);
            #1;
        end
        q3.push_back(0);
        q3.push_back(1);
        req3 = 3'b011;
        repeat (15) begin
            @(posedge clk);
            #1;
        end
        req3 = '0;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1);
    end

endmodule

// File: doc/output_port_controller.md
# output_port_controller

Per-output-port scheduler of the router. It collects route requests from the input link controllers and grants one input at a time with round-robin priority. It spends one downstream packet credit per grant and issues the one-cycle `transfer_strobe` pulse that starts the granted input's buffer read. It then drives the crossbar select and output-link flit valid for the duration of the packet.

## Interface
- `PORTS`, default 4: number of requesting input ports.
- `PACKET_FLITS`, default 5: flits per packet, header included.
- `CREDITS`, default 4: packet slots in the downstream router's input buffer.
- `SEL_W`, default clog2(PORTS): width of the crossbar select.
- `CRD_W`, default clog2(CREDITS+1): width of the credit counter.

Ports:
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low; 0 resets the block immediately.
- `request_din`  in  PORTS  level request per input port, held high until that port's strobe.
- `credit_in_din`  in  1  one-cycle pulse from the downstream router; one packet slot freed.
- `transfer_strobe_dout`  out  PORTS  one-hot, one-cycle grant pulse; feeds the granted input's `transfer_strobe_din`.
- `port_select_dout`  out  SEL_W  crossbar mux select, the index of the granted port.
- `flit_valid_dout`  out  1  high on every cycle that a packet flit is on the output link.
- `port_busy_dout`  out  1  high whenever the state is not IDLE.
- `credits_dout`  out  CRD_W  current downstream credit count.

## Operation
- FSM states: IDLE, GRANT, ACTIVE. All outputs are registered or decoded from registered state only; there are no combinational paths from input to output.
- **IDLE**
  - Eligible when `|request_din` and `credits != 0`.
  - If eligible: latch the round-robin winner into `port_select_dout`, go to GRANT.
  - Otherwise stay in IDLE.
- **Round robin**
  - Pointer `ptr` (SEL_W bits) resets to 0.
  - The winner is the first asserted request at index `ptr`, `ptr+1`, …, wrapping modulo PORTS.
  - On a grant to port i, `ptr <= (i+1) mod PORTS`, with explicit wrap when PORTS is not a power of two.
- **GRANT** (exactly 1 cycle)
  - `transfer_strobe_dout[sel] = 1`; all other bits are 0.
  - The credit is consumed (decremented) on this cycle.
  - Load the flit counter with PACKET_FLITS, go to ACTIVE.
- **ACTIVE**
  - `flit_valid_dout = 1`; the counter decrements every cycle.
  - When the counter equals 1, go to IDLE. ACTIVE therefore lasts exactly PACKET_FLITS cycles.
  - `request_din` is ignored while in ACTIVE.
- **Credit counter**
  - Resets to CREDITS.
  - `credit_in_din` alone: +1, saturating at CREDITS; an extra pulse at CREDITS is dropped.
  - GRANT alone: −1.
  - Both in the same cycle: unchanged.
  - A grant never occurs at 0, so the counter never underflows.
- `port_select_dout` holds its value from GRANT through ACTIVE and into the following IDLE, until the next winner is latched.
- `port_busy_dout` = (state != IDLE).

## Timing
- Reset values:
  - Outputs: `transfer_strobe_dout = 0`, `port_select_dout = 0`, `flit_valid_dout = 0`, `port_busy_dout = 0`, `credits_dout = CREDITS`.
  - Internal: state IDLE, `ptr = 0`, flit counter 0.
- Grant sequence, with the request seen in IDLE at cycle N:
  - cycle N+1: GRANT; strobe high; `credits_dout` shows the decremented value from N+2.
  - cycles N+2 … N+1+PACKET_FLITS: `flit_valid_dout` high.
  - cycle N+2+PACKET_FLITS: IDLE again. The earliest next strobe is at N+3+PACKET_FLITS.
- Back-to-back packets occupy PACKET_FLITS+2 cycles each. The input buffer's registered read output aligns its first flit with the first `flit_valid_dout` cycle.
- A `credit_in_din` pulse arriving in the cycle where the counter is 0 and a request is pending: the counter is 1 at the next edge, and the grant decision is made in the following IDLE cycle.
- Reset asserted mid-packet (any state): all outputs go to reset values asynchronously, and no strobe is emitted. After release, the block waits one IDLE cycle before any grant.

## Test plan
- **Single packet:** PORTS=4, reset release, `request_din=4'b0100` held → strobe `4'b0100` for exactly 1 cycle, `port_select_dout=2`, `flit_valid_dout` high for 5 cycles, `credits_dout` 4→3.
- **Round robin:** `request_din=4'b1111` constant → strobes in order ports 0, 1, 2, 3, 0, each 7 cycles apart. Add `credit_in_din` pulses so credits never block.
- **Credit exhaustion:** 4 grants with no `credit_in_din` → `credits_dout=0` and no further strobe while requests stay high. One credit pulse → strobe 2 cycles later, `credits_dout` 1→0.
- **Simultaneous credit and grant:** `credit_in_din` pulse in the GRANT cycle at credits=2 → `credits_dout` stays 2. Extra pulses at credits=4 → stays 4.
- **Pointer wrap:** PORTS=3, `request_din=3'b011` after a grant to port 2 → next grant goes to port 0, then port 1.
- **Reset mid-operation:** drive `reset` low during the 3rd ACTIVE cycle → `flit_valid_dout` and `port_busy_dout` drop immediately, `credits_dout=4`. After release, the first grant goes to the lowest-index requester.
